// File: rtl/gamepad_reader_if.sv
// Pad-side and host-side signals of the gamepad reader, grouped for port use.
interface gamepad_reader_if;
  logic       start;
  logic       ser_data_in;
  logic       ser_latch;
  logic       ser_pulse;
  logic [7:0] buttons;
  logic       valid;
  logic       changed;
  logic       busy;

  // Reader side: drives the pad protocol and publishes the button byte
  modport master (
    input  start, ser_data_in,
    output ser_latch, ser_pulse, buttons, valid, changed, busy
  );

  // Environment side: requests polls, supplies pad DATA, consumes the byte
  modport slave (
    output start, ser_data_in,
    input  ser_latch, ser_pulse, buttons, valid, changed, busy
  );
endinterface

// File: rtl/gamepad_reader.sv
// NES/Famiclone pad reader: generates LATCH/PULSE, shifts in DATA MSB-first and
// publishes an active-low button byte (A..Right = bit7..bit0).
// Optional GAMEPAD_DEBOUNCE_EN: publish only after two identical consecutive frames.
module gamepad_reader #(
  parameter int unsigned HALF_CYC = 300,
  parameter int unsigned POLL_CYC = 833333
) (
  input logic              CLOCK_50,
  input logic              reset_n,
  gamepad_reader_if.master pad
);

  localparam int unsigned PHASE_W = $clog2(2 * HALF_CYC);
  localparam int unsigned POLL_W  = $clog2(POLL_CYC);

  typedef enum logic [2:0] {
    IDLE, LATCH_HI, LATCH_LO, PULSE_HI, PULSE_LO, DONE
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [POLL_W-1:0]  poll;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [1:0]         sync;
`ifdef GAMEPAD_DEBOUNCE_EN
  logic [7:0]         cand;
`endif

  logic       last_half;
  logic       last_latch;
  logic       poll_due;
  logic [7:0] next_frame;

  assign last_half  = (phase == PHASE_W'(HALF_CYC - 1));
  assign last_latch = (phase == PHASE_W'(2 * HALF_CYC - 1));
  assign poll_due   = (poll == POLL_W'(POLL_CYC - 1));
  assign next_frame = {shreg[6:0], sync[1]};

  // Two-flop synchronizer for the asynchronous pad DATA line
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], pad.ser_data_in};
  end

  // Protocol FSM with poll timer; all pad and host outputs registered
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase         <= '0;
      poll          <= '0;
      bit_cnt       <= '0;
      shreg         <= 8'hFF;
      pad.ser_latch <= 1'b0;
      pad.ser_pulse <= 1'b0;
      pad.buttons   <= 8'hFF;
      pad.valid     <= 1'b0;
      pad.changed   <= 1'b0;
      pad.busy      <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
      cand          <= 8'hFF;
`endif
    end else begin
      pad.valid   <= 1'b0;
      pad.changed <= 1'b0;
      case (state)
        IDLE: begin
          if (pad.start || poll_due) begin
            poll          <= '0;
            phase         <= '0;
            state         <= LATCH_HI;
            pad.ser_latch <= 1'b1;
            pad.busy      <= 1'b1;
          end else begin
            poll <= poll + POLL_W'(1);
          end
        end
        LATCH_HI: begin
          if (last_latch) begin
            phase         <= '0;
            state         <= LATCH_LO;
            pad.ser_latch <= 1'b0;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        LATCH_LO: begin
          if (last_half) begin
            shreg         <= next_frame;
            phase         <= '0;
            bit_cnt       <= 3'd1;
            state         <= PULSE_HI;
            pad.ser_pulse <= 1'b1;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        PULSE_HI: begin
          if (last_half) begin
            phase         <= '0;
            state         <= PULSE_LO;
            pad.ser_pulse <= 1'b0;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        PULSE_LO: begin
          if (last_half) begin
            shreg <= next_frame;
            phase <= '0;
            if (bit_cnt == 3'd7) begin
              // Publish on entry so buttons/valid/changed line up in DONE
              state <= DONE;
`ifdef GAMEPAD_DEBOUNCE_EN
              if (next_frame == cand) begin
                pad.buttons <= next_frame;
                pad.valid   <= 1'b1;
                pad.changed <= (next_frame != pad.buttons);
              end else begin
                cand <= next_frame;
              end
`else
              pad.buttons <= next_frame;
              pad.valid   <= 1'b1;
              pad.changed <= (next_frame != pad.buttons);
`endif
            end else begin
              bit_cnt       <= bit_cnt + 3'd1;
              state         <= PULSE_HI;
              pad.ser_pulse <= 1'b1;
            end
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          pad.busy <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          pad.ser_latch <= 1'b0;
          pad.ser_pulse <= 1'b0;
          pad.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: timeline model of a poll transaction plus pad model.
`timescale 1ns/1ps
module tb_gamepad_reader;

  localparam int H  = 4;
  localparam int P  = 200;
  localparam int TL = 17 * H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gamepad_reader_if gif ();

  gamepad_reader #(.HALF_CYC(H), .POLL_CYC(P)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .pad      (gif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Pad shift register: LATCH loads the frame, each PULSE rise shifts, DATA = MSB
  logic [7:0] pad_frame = 8'hFF;
  logic [7:0] pad_reg   = 8'hFF;
  always @(posedge gif.ser_latch or posedge gif.ser_pulse) begin
    if (gif.ser_latch) pad_reg = pad_frame;
    else               pad_reg = {pad_reg[6:0], 1'b1};
  end
  assign gif.ser_data_in = pad_reg[7];

  // Cycle count since reset release
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc++;
  end

  // Model: m_k is the position within a transaction (0 = idle, 1 = first LATCH cycle)
  int         m_k       = 0;
  int         m_idle    = 0;
  logic [7:0] m_frame   = 8'hFF;
  logic [7:0] m_buttons = 8'hFF;
  logic [7:0] m_cand    = 8'hFF;
  logic       m_valid   = 1'b0;
  logic       m_changed = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_idle = 0; m_buttons = 8'hFF; m_cand = 8'hFF;
      m_valid = 1'b0; m_changed = 1'b0;
    end else begin
      m_valid   = 1'b0;
      m_changed = 1'b0;
      if (m_k == 0) begin
        if (gif.start || m_idle == P - 1) begin
          m_k = 1; m_idle = 0; m_frame = pad_frame;
        end else begin
          m_idle++;
        end
      end else if (m_k == TL + 1) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_k == TL + 1) begin
`ifdef GAMEPAD_DEBOUNCE_EN
          if (m_frame != m_cand) m_cand = m_frame;
          else begin
            m_valid = 1'b1; m_changed = (m_frame != m_buttons); m_buttons = m_frame;
          end
`else
          m_valid = 1'b1; m_changed = (m_frame != m_buttons); m_buttons = m_frame;
`endif
        end
      end
    end
  end

  function automatic int exp_latch(input int k);
    return (k >= 1 && k <= 2 * H) ? 1 : 0;
  endfunction

  function automatic int exp_pulse(input int k);
    if (k < 3 * H + 1 || k > TL) return 0;
    return (((k - 3 * H - 1) % (2 * H)) < H) ? 1 : 0;
  endfunction

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    check("latch",   int'(gif.ser_latch), exp_latch(m_k));
    check("pulse",   int'(gif.ser_pulse), exp_pulse(m_k));
    check("busy",    int'(gif.busy),      (m_k != 0) ? 1 : 0);
    check("valid",   int'(gif.valid),     int'(m_valid));
    check("changed", int'(gif.changed),   int'(m_changed));
    check("buttons", int'(gif.buttons),   int'(m_buttons));
  end

  // Waveform/event monitor feeding the literal checks
  int lr_cnt = 0, end_cnt = 0, valid_cnt = 0;
  int latch_rise = 0, done_cyc = 0, v_cyc = 0, v_buttons = 0, v_changed = 0;
  int latch_len = 0, hi_len = 0, lo_len = 0, n_pulse = 0, bad_width = 0, bad_gap = 0;
  logic prev_latch = 1'b0, prev_pulse = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (gif.ser_latch && !prev_latch) begin
      lr_cnt++; latch_rise = cyc; latch_len = 0; n_pulse = 0; bad_width = 0; bad_gap = 0;
    end
    if (gif.ser_latch) latch_len++;
    if (gif.ser_pulse && !prev_pulse && n_pulse > 0 && lo_len != H) bad_gap++;
    if (!gif.ser_pulse && prev_pulse) begin
      n_pulse++;
      if (hi_len != H) bad_width++;
      hi_len = 0;
      lo_len = 0;
    end
    if (gif.ser_pulse) hi_len++;
    else               lo_len++;
    if (gif.valid) begin
      valid_cnt++; v_cyc = cyc; v_buttons = int'(gif.buttons); v_changed = int'(gif.changed);
    end
    if (prev_busy && !gif.busy) begin
      end_cnt++; done_cyc = cyc - 1;
    end
    prev_latch = gif.ser_latch;
    prev_pulse = gif.ser_pulse;
    prev_busy  = gif.busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int budget);
    int c0 = lr_cnt;
    int n  = 0;
    while (lr_cnt == c0 && n < budget) begin tick(); n++; end
    if (lr_cnt == c0) timeout("latch_rise");
  endtask

  task automatic wait_end(input int budget);
    int c0 = end_cnt;
    int n  = 0;
    while (end_cnt == c0 && n < budget) begin tick(); n++; end
    if (end_cnt == c0) timeout("tx_end");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    gif.start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_buttons", int'(gif.buttons), 'hFF);
    check("rst_valid",   int'(gif.valid), 0);
    check("rst_busy",    int'(gif.busy), 0);

    // First automatic poll with a disconnected (all-high) pad
    wait_rise(300);
    check("first_poll_cycle", latch_rise, 200);
    wait_end(200);
    check("tx_length",   done_cyc - latch_rise, 68);
    check("valid_at_done", v_cyc, done_cyc);
    check("latch_width", latch_len, 8);
    check("pulse_count", n_pulse, 7);
    check("pulse_width_errs", bad_width, 0);
    check("pulse_gap_errs",   bad_gap, 0);
    check("first_valid_cnt",  valid_cnt, 1);
    check("first_buttons",    v_buttons, 'hFF);
    check("first_changed",    v_changed, 0);

`ifndef GAMEPAD_DEBOUNCE_EN
    // A and Right pressed
    pad_frame = 8'h7E;
    wait_rise(300);
    check("poll_period", latch_rise - done_cyc, 201);
    wait_end(200);
    check("a_right_buttons", v_buttons, 'h7E);
    check("a_right_changed", v_changed, 1);
    check("a_right_cnt",     valid_cnt, 2);
    wait_rise(300);
    wait_end(200);
    check("repeat_buttons", v_buttons, 'h7E);
    check("repeat_changed", v_changed, 0);
    check("repeat_cnt",     valid_cnt, 3);
`else
    // Debounce: 7E, 7F, 7F publishes only on the second 7F
    pad_frame = 8'h7E;
    wait_rise(300);
    wait_end(200);
    check("deb_7e_cnt", valid_cnt, 1);
    pad_frame = 8'h7F;
    wait_rise(300);
    wait_end(200);
    check("deb_7f_first_cnt", valid_cnt, 1);
    wait_rise(300);
    wait_end(200);
    check("deb_7f_second_cnt", valid_cnt, 2);
    check("deb_buttons", v_buttons, 'h7F);
    check("deb_changed", v_changed, 1);
`endif

    // start while busy is dropped; start in idle launches next cycle
    wait_rise(300);
    repeat (20) tick();
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    wait_end(200);
    repeat (10) tick();
    check("idle_after_busy_start", int'(gif.busy), 0);
    vc = lr_cnt;
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    check("start_latch_next", int'(gif.ser_latch), 1);
    check("start_one_rise", lr_cnt - vc, 1);
    wait_end(200);
    wait_rise(300);
    check("poll_restart", latch_rise - done_cyc, 201);

    // Reset during the 4th PULSE_HI
    while (cyc < latch_rise + 37) tick();
    check("in_4th_pulse", int'(gif.ser_pulse), 1);
    vc = valid_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulse_drop", int'(gif.ser_pulse), 0);
    check("rst_latch_low",  int'(gif.ser_latch), 0);
    check("rst_mid_buttons", int'(gif.buttons), 'hFF);
    check("rst_mid_busy",   int'(gif.busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("no_partial_valid", valid_cnt, vc);
    wait_rise(300);
    check("poll_after_reset", latch_rise, 200);
    wait_end(200);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
